// File: rtl/fake_mario_otg_hpi_pkg.sv
// Shared types and constants for the OTG HPI bus sequencer.
package fake_mario_otg_hpi_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } hpi_state_e;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    // Phase length N becomes a down-count reload of N-1; a length of 0 acts as 1.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        int eff;
        eff = (cyc <= 0) ? 1 : cyc;
        return CNT_W'(eff - 1);
    endfunction

endpackage

// File: rtl/fake_mario_otg_hpi_seq.sv
// Avalon-MM slave to Cypress OTG HPI bus cycle sequencer with
// programmable setup / strobe / hold phase lengths.
//
// state  | meaning
// IDLE   | bus released, waiting for an Avalon read or write
// SETUP  | CS low, address (and write data) presented, strobes high
// STROBE | RD_N or WR_N low; read data captured on the exit edge
// HOLD   | strobes released, CS/address/data still held
// DONE   | CS released, waitrequest dropped for one cycle
module fake_mario_otg_hpi_seq
    import fake_mario_otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LOAD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = phase_load(HOLD_CYC);

    hpi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [1:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       readdata_q, readdata_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              oe_q, oe_d;
    logic              req;
    logic              active_d;

    assign req         = chipselect & (read | write);
    assign waitrequest = req & (state_q != ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = address;
                    wdata_d = writedata;
                    is_wr_d = write;
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (!is_wr_q) begin
                        readdata_d = otg_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin registers are loaded from the upcoming state so they line up with it.
        active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d   = ~active_d;
        rd_n_d   = ~((state_d == ST_STROBE) && !is_wr_d);
        wr_n_d   = ~((state_d == ST_STROBE) && is_wr_d);
        oe_d     = active_d & is_wr_d;
    end

    assign readdata     = readdata_q;
    assign otg_addr     = addr_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_data_out = wdata_q;
    assign otg_data_oe  = oe_q;

endmodule

// File: tb/tb_fake_mario_otg_hpi_seq.sv
// Directed bench for the OTG HPI sequencer: default timing instance plus
// a stretched-timing instance (SETUP 2, STROBE 5, HOLD 0).
module tb_fake_mario_otg_hpi_seq;
    import fake_mario_otg_hpi_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, chipselect2;
    logic        read, write;
    logic [15:0] writedata;
    logic [15:0] otg_data_in;

    logic [15:0] readdata, readdata2;
    logic        waitrequest, waitrequest2;
    logic [1:0]  otg_addr, otg_addr2;
    logic        otg_cs_n, otg_cs_n2;
    logic        otg_rd_n, otg_rd_n2;
    logic        otg_wr_n, otg_wr_n2;
    logic [15:0] otg_data_out, otg_data_out2;
    logic        otg_data_oe, otg_data_oe2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fake_mario_otg_hpi_seq dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .otg_addr(otg_addr), .otg_cs_n(otg_cs_n),
        .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n), .otg_data_out(otg_data_out),
        .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
    );

    fake_mario_otg_hpi_seq #(.SETUP_CYC(2), .STROBE_CYC(5), .HOLD_CYC(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect2),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata2),
        .waitrequest(waitrequest2), .otg_addr(otg_addr2), .otg_cs_n(otg_cs_n2),
        .otg_rd_n(otg_rd_n2), .otg_wr_n(otg_wr_n2), .otg_data_out(otg_data_out2),
        .otg_data_oe(otg_data_oe2), .otg_data_in(otg_data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int overlap;
        int strobe_no_cs;
        int done_seen;
        int cs_low_seen;

        reset_n     = 1'b0;
        address     = 2'd0;
        chipselect  = 1'b0;
        chipselect2 = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = 16'h0;
        otg_data_in = 16'h0;

        // Reset values
        next_cycle();
        next_cycle();
        check("rst_cs_n",   32'(otg_cs_n), 1);
        check("rst_rd_n",   32'(otg_rd_n), 1);
        check("rst_wr_n",   32'(otg_wr_n), 1);
        check("rst_oe",     32'(otg_data_oe), 0);
        check("rst_addr",   32'(otg_addr), 0);
        check("rst_dout",   32'(otg_data_out), 0);
        check("rst_rdata",  32'(readdata), 0);
        check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        next_cycle();

        // Write 0x1234 to ADDRESS register
        address    = HPI_REG_ADDRESS;
        writedata  = 16'h1234;
        write      = 1'b1;
        chipselect = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("wr_cs_n_c%0d", c), 32'(otg_cs_n), (c >= 1 && c <= 5) ? 0 : 1);
            check($sformatf("wr_wr_n_c%0d", c), 32'(otg_wr_n), (c >= 2 && c <= 4) ? 0 : 1);
            check($sformatf("wr_rd_n_c%0d", c), 32'(otg_rd_n), 1);
            check($sformatf("wr_oe_c%0d", c),   32'(otg_data_oe), (c >= 1 && c <= 5) ? 1 : 0);
            check($sformatf("wr_wait_c%0d", c), 32'(waitrequest), (c <= 5) ? 1 : 0);
            if (c >= 1 && c <= 5) begin
                check($sformatf("wr_addr_c%0d", c), 32'(otg_addr), 2);
                check($sformatf("wr_dout_c%0d", c), 32'(otg_data_out), 32'h1234);
            end
            next_cycle();
        end
        chipselect = 1'b0;
        write      = 1'b0;
        check("wr_rdata_untouched", 32'(readdata), 0);
        next_cycle();

        // Read DATA register; pad data valid only during strobe
        address    = HPI_REG_DATA;
        read       = 1'b1;
        chipselect = 1'b1;
        for (int c = 0; c < 7; c++) begin
            otg_data_in = (c >= 2 && c <= 4) ? 16'hBEEF : 16'hDEAD;
            @(negedge clk);
            check($sformatf("rd_rd_n_c%0d", c), 32'(otg_rd_n), (c >= 2 && c <= 4) ? 0 : 1);
            check($sformatf("rd_wr_n_c%0d", c), 32'(otg_wr_n), 1);
            check($sformatf("rd_oe_c%0d", c),   32'(otg_data_oe), 0);
            check($sformatf("rd_wait_c%0d", c), 32'(waitrequest), (c <= 5) ? 1 : 0);
            if (c == 4) check("rd_rdata_before_capture", 32'(readdata), 0);
            if (c == 6) check("rd_rdata_done", 32'(readdata), 32'hBEEF);
            next_cycle();
        end
        chipselect = 1'b0;
        read       = 1'b0;
        next_cycle();

        // Back-to-back write then read with the request never dropped
        address      = HPI_REG_MAILBOX;
        writedata    = 16'h5A5A;
        write        = 1'b1;
        chipselect   = 1'b1;
        otg_data_in  = 16'h0F0F;
        overlap      = 0;
        strobe_no_cs = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 7) begin
                write   = 1'b0;
                read    = 1'b1;
                address = HPI_REG_STATUS;
            end
            @(negedge clk);
            if (!otg_rd_n && !otg_wr_n) overlap++;
            if ((!otg_rd_n || !otg_wr_n) && otg_cs_n) strobe_no_cs++;
            check($sformatf("b2b_cs_n_c%0d", c), 32'(otg_cs_n),
                  ((c >= 1 && c <= 5) || (c >= 8 && c <= 12)) ? 0 : 1);
            check($sformatf("b2b_wait_c%0d", c), 32'(waitrequest), (c == 6 || c == 13) ? 0 : 1);
            check($sformatf("b2b_wr_n_c%0d", c), 32'(otg_wr_n), (c >= 2 && c <= 4) ? 0 : 1);
            check($sformatf("b2b_rd_n_c%0d", c), 32'(otg_rd_n), (c >= 9 && c <= 11) ? 0 : 1);
            if (c == 3)  check("b2b_addr_wr", 32'(otg_addr), 1);
            if (c == 10) check("b2b_addr_rd", 32'(otg_addr), 3);
            if (c == 6)  check("b2b_rdata_after_wr", 32'(readdata), 32'hBEEF);
            if (c == 13) check("b2b_rdata_after_rd", 32'(readdata), 32'h0F0F);
            next_cycle();
        end
        chipselect = 1'b0;
        read       = 1'b0;
        check("b2b_strobe_overlap", 32'(overlap), 0);
        check("b2b_strobe_without_cs", 32'(strobe_no_cs), 0);
        next_cycle();

        // Read and write together: write wins, readdata untouched
        address     = HPI_REG_ADDRESS;
        writedata   = 16'hCAFE;
        read        = 1'b1;
        write       = 1'b1;
        chipselect  = 1'b1;
        otg_data_in = 16'h7777;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("rw_wr_n_c%0d", c), 32'(otg_wr_n), (c >= 2 && c <= 4) ? 0 : 1);
            check($sformatf("rw_rd_n_c%0d", c), 32'(otg_rd_n), 1);
            check($sformatf("rw_oe_c%0d", c),   32'(otg_data_oe), (c >= 1 && c <= 5) ? 1 : 0);
            if (c == 3) check("rw_dout", 32'(otg_data_out), 32'hCAFE);
            if (c == 6) check("rw_rdata", 32'(readdata), 32'h0F0F);
            next_cycle();
        end
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        next_cycle();

        // Request dropped in cycle 2: cycle still completes with full timing
        address    = HPI_REG_MAILBOX;
        writedata  = 16'h3C3C;
        write      = 1'b1;
        chipselect = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                chipselect = 1'b0;
                write      = 1'b0;
            end
            @(negedge clk);
            check($sformatf("drop_cs_n_c%0d", c), 32'(otg_cs_n), (c >= 1 && c <= 5) ? 0 : 1);
            check($sformatf("drop_wr_n_c%0d", c), 32'(otg_wr_n), (c >= 2 && c <= 4) ? 0 : 1);
            if (c == 6) check("drop_done", 32'(dut.state_q), 32'(ST_DONE));
            next_cycle();
        end

        // Reset pulse during the strobe of a write
        address    = HPI_REG_MAILBOX;
        writedata  = 16'hA5A5;
        write      = 1'b1;
        chipselect = 1'b1;
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        check("rst_mid_wr_n_before", 32'(otg_wr_n), 0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_wr_n", 32'(otg_wr_n), 1);
        check("rst_mid_cs_n", 32'(otg_cs_n), 1);
        check("rst_mid_oe",   32'(otg_data_oe), 0);
        check("rst_mid_addr", 32'(otg_addr), 0);
        check("rst_mid_dout", 32'(otg_data_out), 0);
        check("rst_mid_rdata", 32'(readdata), 0);
        chipselect = 1'b0;
        write      = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        done_seen   = 0;
        cs_low_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dut.state_q == ST_DONE) done_seen++;
            if (!otg_cs_n) cs_low_seen++;
            next_cycle();
        end
        check("rst_mid_no_done", 32'(done_seen), 0);
        check("rst_mid_no_cs", 32'(cs_low_seen), 0);
        check("rst_mid_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Stretched timing instance: SETUP 2, STROBE 5, HOLD 0 (acts as 1)
        address     = HPI_REG_DATA;
        read        = 1'b1;
        chipselect2 = 1'b1;
        otg_data_in = 16'h1357;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("p_wait_c%0d", c), 32'(waitrequest2), (c <= 8) ? 1 : 0);
            check($sformatf("p_cs_n_c%0d", c), 32'(otg_cs_n2), (c >= 1 && c <= 8) ? 0 : 1);
            check($sformatf("p_rd_n_c%0d", c), 32'(otg_rd_n2), (c >= 3 && c <= 7) ? 0 : 1);
            if (c == 9) check("p_rdata", 32'(readdata2), 32'h1357);
            next_cycle();
        end
        chipselect2 = 1'b0;
        read        = 1'b0;
        check("p_dut1_untouched", 32'(otg_cs_n), 1);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
